// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: turns three on/off colour levels into crossfading PWM pin drives.
// Ports: clk, rst_n (async, active-low), enable, red_in/green_in/blue_in (target levels),
//        red_pwm/green_pwm/blue_pwm (PWM pins, polarity set by ACTIVE_LOW), fade_busy.
// Latency: 1 cycle for inputs to reach the targets, then 1 duty step per STEP_INTERVAL cycles;
//          a new duty reaches the pins at the start of the next PWM period.
// Backpressure: none. Inputs are sampled every cycle and the outputs are free-running.

`timescale 1ns/1ps

module rgb_pwm_fader #(
    parameter int PWM_BITS      = 8,
    parameter int STEP_INTERVAL = 4700,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic red_in,
    input  logic green_in,
    input  logic blue_in,
    output logic red_pwm,
    output logic green_pwm,
    output logic blue_pwm,
    output logic fade_busy
);

    localparam int NCH = 3;
    localparam int SCW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;

    // Full-on duty. The PWM period is DUTY_MAX cycles, so a duty of DUTY_MAX
    // keeps the pin on for the whole period.
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST  = DUTY_MAX - 1'b1;
    localparam logic [SCW-1:0]      STEP_LAST = SCW'(STEP_INTERVAL - 1);

    localparam logic PIN_OFF = (ACTIVE_LOW != 0);
    localparam logic PIN_ON  = ~PIN_OFF;

    // Channel index: 0 = red, 1 = green, 2 = blue.
    logic [NCH-1:0]      lvl_in;

    logic [SCW-1:0]      step_cnt_q, step_cnt_d;
    logic                step_tick;

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                pwm_wrap;

    logic [NCH-1:0]      tgt_q, tgt_d;
    logic [PWM_BITS-1:0] duty_q [NCH];
    logic [PWM_BITS-1:0] duty_d [NCH];
    logic [PWM_BITS-1:0] dact_q [NCH];
    logic [PWM_BITS-1:0] dact_d [NCH];

    logic [NCH-1:0]      pin_q, pin_d;
    logic                busy_q, busy_d;

    assign lvl_in = {blue_in, green_in, red_in};

    // ------------------------------------------------------------------
    // Step prescaler: one step_tick pulse every STEP_INTERVAL cycles.
    // ------------------------------------------------------------------
    always_comb begin
        step_tick  = (step_cnt_q == STEP_LAST);
        step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // PWM period counter: 0 .. DUTY_MAX-1, wraps.
    // ------------------------------------------------------------------
    always_comb begin
        pwm_wrap  = (pwm_cnt_q == PWM_LAST);
        pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Per-channel target, duty ramp, active duty, pin and busy logic.
    // ------------------------------------------------------------------
    always_comb begin
        // Disabling forces every target to off so all channels fade out.
        tgt_d  = lvl_in & {NCH{enable}};
        busy_d = 1'b0;
        pin_d  = '0;

        for (int ch = 0; ch < NCH; ch++) begin
            duty_d[ch] = duty_q[ch];
            dact_d[ch] = dact_q[ch];

            // Ramp one step toward the target, saturating at 0 and DUTY_MAX.
            // Because the direction is re-evaluated on every tick from the
            // current duty, a target flip mid-ramp simply reverses the ramp.
            if (step_tick) begin
                if (tgt_q[ch] && (duty_q[ch] != DUTY_MAX)) begin
                    duty_d[ch] = duty_q[ch] + 1'b1;
                end else if (!tgt_q[ch] && (duty_q[ch] != '0)) begin
                    duty_d[ch] = duty_q[ch] - 1'b1;
                end
            end

            // The comparator only sees a new duty at a period boundary, so a
            // duty change mid-period cannot truncate or stretch a pulse.
            if (pwm_wrap) begin
                dact_d[ch] = duty_q[ch];
            end

            // On-pulse sits at the start of the period, dact cycles long.
            pin_d[ch] = (pwm_cnt_q < dact_q[ch]) ? PIN_ON : PIN_OFF;

            if (duty_q[ch] != (tgt_q[ch] ? DUTY_MAX : '0)) begin
                busy_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            tgt_q      <= '0;
            busy_q     <= 1'b0;
            // Pins go to the off level as soon as reset asserts, even mid-fade.
            pin_q      <= {NCH{PIN_OFF}};
            for (int ch = 0; ch < NCH; ch++) begin
                duty_q[ch] <= '0;
                dact_q[ch] <= '0;
            end
        end else begin
            step_cnt_q <= step_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            tgt_q      <= tgt_d;
            busy_q     <= busy_d;
            pin_q      <= pin_d;
            for (int ch = 0; ch < NCH; ch++) begin
                duty_q[ch] <= duty_d[ch];
                dact_q[ch] <= dact_d[ch];
            end
        end
    end

    assign red_pwm   = pin_q[0];
    assign green_pwm = pin_q[1];
    assign blue_pwm  = pin_q[2];
    assign fade_busy = busy_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: directed self-checking bench for rgb_pwm_fader.
// Configuration: PWM_BITS=3 (MAX=7, period 7), STEP_INTERVAL=4, ACTIVE_LOW=1 (pin 1 = off).
// Each scenario starts from a reset released on a falling edge; "edge k" is the k-th
// rising edge after release and every sample is taken on the falling edge after it.

`timescale 1ns/1ps

module tb_rgb_pwm_fader;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic red_in;
    logic green_in;
    logic blue_in;
    logic red_pwm;
    logic green_pwm;
    logic blue_pwm;
    logic fade_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int bad;
    int lows;

    rgb_pwm_fader #(
        .PWM_BITS      (3),
        .STEP_INTERVAL (4),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .red_in    (red_in),
        .green_in  (green_in),
        .blue_in   (blue_in),
        .red_pwm   (red_pwm),
        .green_pwm (green_pwm),
        .blue_pwm  (blue_pwm),
        .fade_busy (fade_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Holds reset for two cycles with the given inputs, releases on a falling edge.
    task automatic do_reset(input logic r, input logic g, input logic b, input logic en);
        rst_n    = 1'b0;
        red_in   = r;
        green_in = g;
        blue_in  = b;
        enable   = en;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        red_in   = 1'b0;
        green_in = 1'b0;
        blue_in  = 1'b0;

        // ---------------- 1. reset state, idle, async reset ----------------
        @(negedge clk);
        chk("rst_red",   red_pwm,   1);
        chk("rst_green", green_pwm, 1);
        chk("rst_blue",  blue_pwm,  1);
        chk("rst_busy",  fade_busy, 0);

        do_reset(0, 0, 0, 1);
        bad = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if ({red_pwm, green_pwm, blue_pwm} !== 3'b111 || fade_busy !== 1'b0) bad++;
        end
        chk("idle_pins_off", bad, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("idle_async_rst_red", red_pwm, 1);
        chk("idle_async_rst_busy", fade_busy, 0);

        // ---------------- 2. red ramps up 0 -> 7 ----------------
        do_reset(1, 0, 0, 1);
        bad = 0;
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            if (green_pwm !== 1'b1 || blue_pwm !== 1'b1) bad++;
            if (k == 1)  chk("up_busy_e1", fade_busy, 0);
            if (k == 2)  chk("up_busy_e2", fade_busy, 1);
            if (k == 3)  chk("up_duty_e3", dut.duty_q[0], 0);
            if (k == 4)  chk("up_duty_e4", dut.duty_q[0], 1);
            if (k == 7)  chk("up_duty_e7", dut.duty_q[0], 1);
            if (k == 8)  chk("up_duty_e8", dut.duty_q[0], 2);
            if (k == 27) chk("up_duty_e27", dut.duty_q[0], 6);
            if (k == 28) chk("up_duty_e28", dut.duty_q[0], 7);
            if (k == 28) chk("up_busy_e28", fade_busy, 1);
            if (k == 29) chk("up_busy_e29", fade_busy, 0);
        end
        chk("up_green_blue_off", bad, 0);

        // ---------------- 3. PWM shape, duty 3 latched mid-ramp ----------------
        // dact=3 from edge 14 (period = edges 15..21), dact=5 from edge 21 (edges 22..28).
        do_reset(1, 0, 0, 1);
        bad  = 0;
        lows = 0;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            if (k >= 14) begin
                if (red_pwm !== (((k >= 15 && k <= 17) || (k >= 22 && k <= 26)) ? 1'b0 : 1'b1)) bad++;
            end
            if (k >= 15 && k <= 21 && red_pwm === 1'b0) lows++;
            if (k == 18) chk("pwm3_duty_moved_midperiod", dut.duty_q[0], 4);
        end
        chk("pwm_shape", bad, 0);
        chk("pwm3_low_count", lows, 3);

        // ---------------- 4. red reverses at duty 4 and ramps down ----------------
        do_reset(1, 0, 0, 1);
        repeat (16) @(negedge clk);
        chk("down_duty_start", dut.duty_q[0], 4);
        red_in = 1'b0;
        bad = 0;
        for (int k = 17; k <= 49; k++) begin
            @(negedge clk);
            if (k == 19) chk("down_duty_e19", dut.duty_q[0], 4);
            if (k == 20) chk("down_duty_e20", dut.duty_q[0], 3);
            if (k == 24) chk("down_duty_e24", dut.duty_q[0], 2);
            if (k == 28) chk("down_duty_e28", dut.duty_q[0], 1);
            if (k == 32) chk("down_duty_e32", dut.duty_q[0], 0);
            if (k == 32) chk("down_busy_e32", fade_busy, 1);
            if (k == 33) chk("down_busy_e33", fade_busy, 0);
            if (k >= 36 && red_pwm !== 1'b1) bad++;
        end
        chk("down_pin_const_off", bad, 0);
        chk("down_duty_floor", dut.duty_q[0], 0);

        // ---------------- 5. all on, then enable=0 fades all ----------------
        do_reset(1, 1, 1, 1);
        repeat (35) @(negedge clk);
        bad = 0;
        for (int k = 36; k <= 56; k++) begin
            @(negedge clk);
            if ({red_pwm, green_pwm, blue_pwm} !== 3'b000) bad++;
        end
        chk("full_pins_on", bad, 0);
        chk("full_busy", fade_busy, 0);
        chk("full_duty_ceiling", dut.duty_q[1], 7);
        enable = 1'b0;
        bad = 0;
        for (int k = 57; k <= 85; k++) begin
            @(negedge clk);
            if (dut.duty_q[0] !== dut.duty_q[1] || dut.duty_q[0] !== dut.duty_q[2]) bad++;
            if (k == 57) chk("dis_busy_e57", fade_busy, 0);
            if (k == 58) chk("dis_busy_e58", fade_busy, 1);
            if (k == 60) chk("dis_duty_e60", dut.duty_q[0], 6);
            if (k == 84) chk("dis_duty_r_e84", dut.duty_q[0], 0);
            if (k == 84) chk("dis_duty_g_e84", dut.duty_q[1], 0);
            if (k == 84) chk("dis_duty_b_e84", dut.duty_q[2], 0);
            if (k == 84) chk("dis_busy_e84", fade_busy, 1);
            if (k == 85) chk("dis_busy_e85", fade_busy, 0);
        end
        chk("dis_lockstep", bad, 0);

        // ---------------- 6. reset mid-fade, restart timing ----------------
        do_reset(1, 0, 0, 1);
        repeat (22) @(negedge clk);
        chk("mid_pin_on", red_pwm, 0);
        chk("mid_duty", dut.duty_q[0], 5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_pin", red_pwm, 1);
        chk("mid_async_busy", fade_busy, 0);
        chk("mid_async_duty", dut.duty_q[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("restart_duty_e3", dut.duty_q[0], 0);
        @(negedge clk);
        chk("restart_duty_e4", dut.duty_q[0], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
